// File: rtl/in_deser_cell.sv
// Serial-to-parallel input stage behind the IO input register.
// Assembles WIDTH-bit words from IQZ and hands them to fabric via valid/ready.
module in_deser_cell #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             IQZ,
  input  logic             FRAME,
  input  logic             F2A_RDY,
  output logic [WIDTH-1:0] A2F_DATA,
  output logic             A2F_VLD,
  output logic             A2F_OVF,
  output logic             A2F_BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] shifted, seeded;
  logic [WIDTH-1:0] data_n;
  logic             vld_n, ovf_n, busy_n;
  logic             done;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr[WIDTH-2:0], IQZ};
      seeded  = {{(WIDTH-1){1'b0}}, IQZ};
    end else begin
      shifted = {IQZ, sr[WIDTH-1:1]};
      seeded  = {IQZ, {(WIDTH-1){1'b0}}};
    end
  end

  // FRAME always restarts alignment; it also wins over a last-bit cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (FRAME) begin
          sr_n    = seeded;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (FRAME) begin
          sr_n  = seeded;
          cnt_n = CW'(1);
        end else begin
          sr_n = shifted;
          if (cnt == LAST) begin
            cnt_n = '0;
            done  = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    data_n = A2F_DATA;
    vld_n  = A2F_VLD;
    ovf_n  = A2F_OVF;
    busy_n = (state_n == SHIFT) && (cnt_n != '0);
    if (done) begin
      if (!A2F_VLD || F2A_RDY) begin
        data_n = shifted;
        vld_n  = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end else if (A2F_VLD && F2A_RDY) begin
      vld_n = 1'b0;
    end
  end

  always_ff @(posedge IQC) begin
    if (QRT) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      A2F_DATA <= '0;
      A2F_VLD  <= 1'b0;
      A2F_OVF  <= 1'b0;
      A2F_BUSY <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sr       <= sr_n;
      A2F_DATA <= data_n;
      A2F_VLD  <= vld_n;
      A2F_OVF  <= ovf_n;
      A2F_BUSY <= busy_n;
    end
  end

endmodule

// File: tb/tb_in_deser_cell.sv
// Bench for in_deser_cell: MSB-first and LSB-first instances on one stream,
// checked every cycle against a bit-position model plus literal pins.
module tb_in_deser_cell;

  logic       IQC = 1'b0;
  logic       QRT, IQZ, FRAME, F2A_RDY;
  logic [7:0] data_m, data_l;
  logic       vld_m, ovf_m, busy_m;
  logic       vld_l, ovf_l, busy_l;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  always #5 IQC = ~IQC;

  in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .IQC(IQC), .QRT(QRT), .IQZ(IQZ), .FRAME(FRAME), .F2A_RDY(F2A_RDY),
    .A2F_DATA(data_m), .A2F_VLD(vld_m), .A2F_OVF(ovf_m), .A2F_BUSY(busy_m)
  );

  in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .IQC(IQC), .QRT(QRT), .IQZ(IQZ), .FRAME(FRAME), .F2A_RDY(F2A_RDY),
    .A2F_DATA(data_l), .A2F_VLD(vld_l), .A2F_OVF(ovf_l), .A2F_BUSY(busy_l)
  );

  // Model: bit k of a word goes to position 7-k (MSB first) or k (LSB first).
  bit       m_act  [2];
  int       m_k    [2];
  bit [7:0] m_word [2];
  bit [7:0] m_data [2];
  bit       m_vld  [2];
  bit       m_ovf  [2];
  bit       m_busy [2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_act[c] = 0; m_k[c] = 0; m_word[c] = 0; m_data[c] = 0;
      m_vld[c] = 0; m_ovf[c] = 0; m_busy[c] = 0;
    end
  end

  always @(posedge IQC) begin
    for (int c = 0; c < 2; c++) begin
      bit cmp;
      int pos;
      cmp = 0;
      if (QRT) begin
        m_act[c] = 0; m_k[c] = 0; m_word[c] = 0; m_data[c] = 0;
        m_vld[c] = 0; m_ovf[c] = 0; m_busy[c] = 0;
      end else begin
        if (FRAME) begin
          m_word[c] = 0;
          pos = (c == 0) ? 7 : 0;
          m_word[c][pos] = IQZ;
          m_k[c] = 1;
          m_act[c] = 1;
        end else if (m_act[c]) begin
          pos = (c == 0) ? 7 - m_k[c] : m_k[c];
          m_word[c][pos] = IQZ;
          m_k[c]++;
          if (m_k[c] == 8) begin
            cmp = 1;
            m_k[c] = 0;
          end
        end
        if (cmp) begin
          if (!m_vld[c] || F2A_RDY) begin
            m_data[c] = m_word[c];
            m_vld[c] = 1;
          end else begin
            m_ovf[c] = 1;
          end
          m_word[c] = 0;
        end else if (m_vld[c] && F2A_RDY) begin
          m_vld[c] = 0;
        end
        m_busy[c] = m_act[c] && (m_k[c] != 0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge IQC) begin
    if (run) begin
      chk("msb_data", 32'(data_m), 32'(m_data[0]));
      chk("msb_vld",  32'(vld_m),  32'(m_vld[0]));
      chk("msb_ovf",  32'(ovf_m),  32'(m_ovf[0]));
      chk("msb_busy", 32'(busy_m), 32'(m_busy[0]));
      chk("lsb_data", 32'(data_l), 32'(m_data[1]));
      chk("lsb_vld",  32'(vld_l),  32'(m_vld[1]));
      chk("lsb_ovf",  32'(ovf_l),  32'(m_ovf[1]));
      chk("lsb_busy", 32'(busy_l), 32'(m_busy[1]));
    end
  end

  task automatic step(input logic f, input logic b, input logic r);
    FRAME = f;
    IQZ = b;
    F2A_RDY = r;
    @(posedge IQC);
    #1;
  endtask

  // Sends v[7] first; FRAME on the first bit when frm is set.
  task automatic send(input logic [7:0] v, input logic frm, input logic r);
    for (int i = 7; i >= 0; i--)
      step((i == 7) ? frm : 1'b0, v[i], r);
  endtask

  task automatic pin(input string nm, input logic [7:0] d, input logic v,
                     input logic o, input logic b, input logic [7:0] ed,
                     input logic ev, input logic eo, input logic eb);
    chk({nm, "_data"}, 32'(d), 32'(ed));
    chk({nm, "_vld"},  32'(v), 32'(ev));
    chk({nm, "_ovf"},  32'(o), 32'(eo));
    chk({nm, "_busy"}, 32'(b), 32'(eb));
  endtask

  initial begin
    QRT = 1'b1; FRAME = 1'b0; IQZ = 1'b0; F2A_RDY = 1'b0;
    @(posedge IQC); #1;
    step(1'b0, 1'b0, 1'b0);
    run = 1'b1;
    pin("reset", data_m, vld_m, ovf_m, busy_m, 8'h00, 0, 0, 0);
    QRT = 1'b0;

    // 0xA5 is a palindrome, so both bit orders give 0xA5
    send(8'hA5, 1'b1, 1'b1);
    pin("a5_msb", data_m, vld_m, ovf_m, busy_m, 8'hA5, 1, 0, 0);
    pin("a5_lsb", data_l, vld_l, ovf_l, busy_l, 8'hA5, 1, 0, 0);

    // streaming without FRAME: bits 1,1,0,0,0,0,0,0
    step(1'b0, 1'b1, 1'b1);
    chk("a5_one_cycle", 32'(vld_m), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, (i == 0), 1'b1);
    pin("c0_msb", data_m, vld_m, ovf_m, busy_m, 8'hC0, 1, 0, 0);
    pin("03_lsb", data_l, vld_l, ovf_l, busy_l, 8'h03, 1, 0, 0);

    // back-pressure: 0x3C then 0xF0 while not ready
    step(1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) step(1'b0, 8'h3C >> i, 1'b0);
    pin("3c_msb", data_m, vld_m, ovf_m, busy_m, 8'h3C, 1, 0, 0);
    send(8'hF0, 1'b0, 1'b0);
    pin("ovf_msb", data_m, vld_m, ovf_m, busy_m, 8'h3C, 1, 1, 0);
    pin("ovf_lsb", data_l, vld_l, ovf_l, busy_l, 8'h3C, 1, 1, 0);
    step(1'b0, 1'b0, 1'b1);
    pin("drain", data_m, vld_m, ovf_m, busy_m, 8'h3C, 0, 1, 1);

    // realign after 5 bits, then 0x81
    QRT = 1'b1; step(1'b0, 1'b0, 1'b0); QRT = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    chk("part_busy", 32'(busy_m), 32'd1);
    send(8'h81, 1'b1, 1'b1);
    pin("81_msb", data_m, vld_m, ovf_m, busy_m, 8'h81, 1, 0, 0);

    // FRAME on the 8th bit suppresses the word
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    pin("frame8", data_m, vld_m, ovf_m, busy_m, 8'h81, 0, 0, 1);

    // 0x11 held, then 0x22 completes on the accepting edge
    send(8'h11, 1'b1, 1'b0);
    pin("11_msb", data_m, vld_m, ovf_m, busy_m, 8'h11, 1, 0, 0);
    for (int i = 7; i >= 1; i--) step(1'b0, 8'h22 >> i, 1'b0);
    chk("hold_11", 32'(data_m), 32'h11);
    step(1'b0, 1'b0, 1'b1);
    pin("22_msb", data_m, vld_m, ovf_m, busy_m, 8'h22, 1, 0, 0);
    chk("44_lsb", 32'(data_l), 32'h44);

    // reset mid-word with a held word; FRAME in same cycle must lose
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    QRT = 1'b1; step(1'b1, 1'b1, 1'b0); QRT = 1'b0;
    pin("qrt_msb", data_m, vld_m, ovf_m, busy_m, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    pin("no_frame", data_m, vld_m, ovf_m, busy_m, 8'h00, 0, 0, 0);
    for (int i = 7; i >= 1; i--) step(i == 7, 8'hA5 >> i, 1'b1);
    chk("pre_a5", 32'(vld_m), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    pin("post_a5", data_m, vld_m, ovf_m, busy_m, 8'hA5, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1);

    @(negedge IQC); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/in_deser_cell.md
Name: in_deser_cell

Overview:
- Serial-to-parallel input stage sitting directly downstream of the IO input register cell.
- Consumes the registered pad bit (IQZ) every IQC cycle and assembles WIDTH-bit words.
- Presents each word to fabric with a valid/ready handshake.
- Flags words that are dropped while fabric back-pressures.

Parameters:
- WIDTH, 8: bits per deserialized word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in A2F_DATA[WIDTH-1]; 0 = first bit lands in A2F_DATA[0].

Ports:
- IQC  input  1  clock, same clock as the upstream input register; all state updates on posedge.
- QRT  input  1  reset, synchronous, active-high.
- IQZ  input  1  serial data from the upstream input register output.
- FRAME  input  1  word-alignment strobe; high in the cycle whose IQZ is bit 0 of a new word.
- F2A_RDY  input  1  fabric ready to accept A2F_DATA.
- A2F_DATA  output  WIDTH  last completed word.
- A2F_VLD  output  1  A2F_DATA holds an unaccepted word.
- A2F_OVF  output  1  sticky: at least one completed word was dropped.
- A2F_BUSY  output  1  high while a word is partially assembled (state SHIFT, bit count > 0).

Behaviour:
- Internal state:
  - FSM states IDLE and SHIFT.
  - Shift register SR[WIDTH-1:0].
  - Bit counter CNT, clog2(WIDTH) bits wide.
  - Output holding register feeding A2F_DATA.
- Reset (QRT=1 at a posedge): state=IDLE, CNT=0, SR=0, A2F_DATA=0, A2F_VLD=0, A2F_OVF=0, A2F_BUSY=0. Reset has priority over every other input in the same cycle. A partial word or an unaccepted word is discarded.
- IDLE:
  - IQZ is ignored until FRAME=1.
  - When FRAME=1: capture IQZ as bit 0, CNT<=1, state<=SHIFT.
- SHIFT:
  - Each cycle, capture IQZ into SR and increment CNT.
  - MSB_FIRST=1: shift left, insert at LSB.
  - MSB_FIRST=0: shift right, insert at MSB.
- Word complete: the cycle in which CNT==WIDTH-1 and a bit is captured.
  - The completed word, including the current bit, is written to the holding register at that edge.
  - CNT wraps to 0. State stays SHIFT (continuous streaming), so the next cycle's bit is bit 0 of the next word without needing FRAME.
- Latency: A2F_VLD rises on the edge that samples the last bit. A2F_DATA is valid in the cycle immediately after that edge.
- FRAME while in SHIFT with CNT!=0:
  - The partial word is discarded.
  - The current IQZ is taken as bit 0 and CNT<=1.
  - No A2F_OVF.
- FRAME coinciding with the last-bit cycle: FRAME wins. The partial word is discarded, no word is emitted, and IQZ becomes bit 0.
- Handshake:
  - A transfer occurs on any posedge with A2F_VLD=1 and F2A_RDY=1.
  - A2F_DATA and A2F_VLD are stable while A2F_VLD=1 and F2A_RDY=0.
  - Transfer with no completion in the same cycle: A2F_VLD<=0.
  - Completion and transfer in the same cycle: the new word loads and A2F_VLD stays 1 (no bubble).
  - Completion while A2F_VLD=1 and F2A_RDY=0: the new word is dropped, the held word is kept, and A2F_OVF<=1.
- A2F_OVF stays set until QRT only.
- A2F_BUSY = (state==SHIFT) && (CNT!=0), registered.
- F2A_RDY has no combinational path to any output.

Test Plan:
- Reset, W=8, MSB_FIRST=1: FRAME with bit 1, then bits 0,1,0,0,1,0,1 (0xA5), F2A_RDY=1 -> A2F_VLD high for exactly 1 cycle after the 8th-bit edge, A2F_DATA=0xA5, A2F_OVF=0.
- MSB_FIRST=0, same bit stream -> A2F_DATA=0xA5 bit-reversed, i.e. 0xA5. Then stream 1,1,0,0,0,0,0,0 with no second FRAME -> A2F_DATA=0x03 exactly 8 cycles after the first word.
- Back-pressure: F2A_RDY=0, two consecutive words 0x3C then 0xF0 -> A2F_DATA holds 0x3C, A2F_VLD stays 1, A2F_OVF=1 after the 0xF0 completion edge. Raise F2A_RDY -> A2F_VLD falls next cycle, A2F_OVF stays 1.
- Realign: after 5 bits, FRAME pulses, then 8 bits 0x81 -> only 0x81 emitted, no OVF. A separate case with FRAME on the 8th bit emits no word.
- Simultaneous completion and accept: continuous stream 0x11, 0x22, F2A_RDY=1 at the 0x22 completion edge -> A2F_VLD stays 1 with no gap, A2F_DATA=0x22.
- QRT asserted mid-word (after 3 bits) and with A2F_VLD=1 -> next cycle all outputs 0, state IDLE. Bits without FRAME are ignored, and the first word is emitted only 8 bits after the next FRAME.
